// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C byte controller between NUM_REQ requesters.
// Define I2C_ARB_TIMEOUT_EN to add a watchdog that aborts a stuck controller (ctl_abort).
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic                       ctl_start,
  output logic [ADDR_W-1:0]          ctl_addr,
  output logic                       ctl_rw,
  output logic [DATA_W-1:0]          ctl_wdata,
  input  logic                       ctl_busy,
  input  logic                       ctl_done,
  input  logic [DATA_W-1:0]          ctl_rdata,
  input  logic                       ctl_nack,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic                       ctl_abort
`endif
);

  localparam int               GID_W    = $clog2(NUM_REQ);
  localparam logic [GID_W:0]   REQ_CNT  = (GID_W+1)'(NUM_REQ);
  localparam logic [GID_W-1:0] LAST_IDX = GID_W'(NUM_REQ-1);

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_ISSUE     = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_RESP      = 3'd4
  } arb_state_t;

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [GID_W-1:0]     r_rr_ptr;
  logic [GID_W-1:0]     r_grant;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_ctl_start;
  logic [ADDR_W-1:0]    r_ctl_addr;
  logic                 r_ctl_rw;
  logic [DATA_W-1:0]    r_ctl_wdata;
  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [GID_W-1:0]     w_off;
  logic [GID_W:0]       w_sum;
  logic [GID_W-1:0]     w_pick;
  logic                 w_any;
  logic                 w_expire;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [GID_W-1:0] idx);
    f_onehot      = '0;
    f_onehot[idx] = 1'b1;
  endfunction

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, then un-rotate.
  always_comb begin
    w_req_dbl = {req_valid, req_valid} >> r_rr_ptr;
    w_req_rot = w_req_dbl[NUM_REQ-1:0];
    w_any     = |w_req_rot;
    w_off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_off = w_req_rot[k] ? GID_W'(k) : w_off;
    end
    w_sum  = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_pick = (w_sum >= REQ_CNT) ? GID_W'(w_sum - REQ_CNT) : w_sum[GID_W-1:0];
  end

  // Next-state decode; a done pulse outranks a simultaneous watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_any && !ctl_busy) begin
          w_state_nxt = ARB_ISSUE;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_ISSUE: w_state_nxt = ARB_WAIT_BUSY;
      ARB_WAIT_BUSY: begin
        if (ctl_done || w_expire) begin
          w_state_nxt = ARB_RESP;
        end else if (ctl_busy) begin
          w_state_nxt = ARB_WAIT_DONE;
        end else begin
          w_state_nxt = ARB_WAIT_BUSY;
        end
      end
      ARB_WAIT_DONE: begin
        if (ctl_done || w_expire) begin
          w_state_nxt = ARB_RESP;
        end else begin
          w_state_nxt = ARB_WAIT_DONE;
        end
      end
      ARB_RESP: w_state_nxt = ARB_IDLE;
      default:  w_state_nxt = ARB_IDLE;
    endcase
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  logic        r_ctl_abort;

  // Watchdog restarts on entry to WAIT_BUSY and runs through both wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= 16'd0;
    end else if (r_state == ARB_ISSUE) begin
      r_wdog <= 16'd0;
    end else if ((r_state == ARB_WAIT_BUSY) || (r_state == ARB_WAIT_DONE)) begin
      r_wdog <= r_wdog + 16'd1;
    end else begin
      r_wdog <= r_wdog;
    end
  end

  assign w_expire  = ((r_state == ARB_WAIT_BUSY) || (r_state == ARB_WAIT_DONE)) &&
                     (r_wdog == 16'(TIMEOUT_CYCLES - 1));
  assign ctl_abort = r_ctl_abort;
`else
  assign w_expire  = 1'b0;
`endif

  // State, pointer, latched transaction and the registered handshake pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_ctl_start <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_rw    <= 1'b0;
      r_ctl_wdata <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_ctl_abort <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= '0;
      r_ctl_start <= 1'b0;
      r_rsp_valid <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_ctl_abort <= 1'b0;
`endif
      case (r_state)
        ARB_IDLE: begin
          if (w_state_nxt == ARB_ISSUE) begin
            r_grant     <= w_pick;
            r_ctl_addr  <= req_addr[w_pick*ADDR_W +: ADDR_W];
            r_ctl_rw    <= req_rw[w_pick];
            r_ctl_wdata <= req_wdata[w_pick*DATA_W +: DATA_W];
            r_req_ready <= f_onehot(w_pick);
            r_ctl_start <= 1'b1;
          end
        end
        ARB_WAIT_BUSY, ARB_WAIT_DONE: begin
          if (ctl_done) begin
            r_rsp_rdata <= ctl_rdata;
            r_rsp_err   <= ctl_nack;
            r_rsp_valid <= f_onehot(r_grant);
          end else if (w_expire) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= f_onehot(r_grant);
`ifdef I2C_ARB_TIMEOUT_EN
            r_ctl_abort <= 1'b1;
`endif
          end
        end
        ARB_RESP: begin
          r_rr_ptr <= (r_grant == LAST_IDX) ? '0 : r_grant + GID_W'(1);
        end
        default: begin
          r_rr_ptr <= r_rr_ptr;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign ctl_start = r_ctl_start;
  assign ctl_addr  = r_ctl_addr;
  assign ctl_rw    = r_ctl_rw;
  assign ctl_wdata = r_ctl_wdata;
  assign grant_id  = r_grant;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: stimulus queues expected issues/responses,
// a negedge monitor pops and compares them; a small behavioural controller answers starts.
module tb_i2c_txn_arbiter;
  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_rw;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            ctl_start;
  logic [AW-1:0]   ctl_addr;
  logic            ctl_rw;
  logic [DW-1:0]   ctl_wdata;
  logic            ctl_busy;
  logic            ctl_done;
  logic [DW-1:0]   ctl_rdata;
  logic            ctl_nack;
  logic [1:0]      grant_id;
  logic            model_done;
  logic            stray_done;
  logic            w_abort;

  assign ctl_done = model_done | stray_done;

`ifdef I2C_ARB_TIMEOUT_EN
  logic ctl_abort;
  assign w_abort = ctl_abort;
`else
  assign w_abort = 1'b0;
`endif

  logic [AW-1:0] t_addr [N];
  logic          t_rw   [N];
  logic [DW-1:0] t_wd   [N];

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*AW +: AW]  = t_addr[g];
    assign req_rw[g]             = t_rw[g];
    assign req_wdata[g*DW +: DW] = t_wd[g];
  end

  i2c_txn_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rw(req_rw), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ctl_start(ctl_start), .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_wdata(ctl_wdata),
    .ctl_busy(ctl_busy), .ctl_done(ctl_done), .ctl_rdata(ctl_rdata), .ctl_nack(ctl_nack),
    .grant_id(grant_id)
`ifdef I2C_ARB_TIMEOUT_EN
    , .ctl_abort(ctl_abort)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int gid; logic [AW-1:0] addr; logic rw; logic [DW-1:0] wd; } iss_t;
  typedef struct { int gid; logic [DW-1:0] rdata; logic err; logic [AW-1:0] addr; logic tmo; } rsp_t;
  typedef struct { logic [DW-1:0] rdata; logic nack; logic hang; } ctl_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];
  ctl_t exp_ctl[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_done   = 0;
  int n_hang   = 0;

  function automatic logic [N-1:0] oh(input int g);
    oh    = '0;
    oh[g] = 1'b1;
  endfunction

  // Monitor: every issue or response the DUT presents must match the head of its queue.
  iss_t m_ie;
  rsp_t m_re;
  logic m_ok;
  always @(negedge clk) begin
    if (!rst) begin
      if (model_done) n_done++;
      if (ctl_start || (req_ready != '0)) begin
        if (ctl_start) n_start++;
        n_checks++;
        if (exp_iss.size() == 0) begin
          n_errors++;
          $display("FAIL issue_unexpected: got ready=%b start=%b gid=%0d, required no issue", req_ready, ctl_start, grant_id);
        end else begin
          m_ie = exp_iss.pop_front();
          if (!(req_ready == oh(m_ie.gid) && ctl_start && ctl_addr == m_ie.addr &&
                ctl_rw == m_ie.rw && ctl_wdata == m_ie.wd && grant_id == 2'(m_ie.gid))) begin
            n_errors++;
            $display("FAIL issue: got ready=%b start=%b addr=%h rw=%b wdata=%h gid=%0d, required ready=%b start=1 addr=%h rw=%b wdata=%h gid=%0d",
                     req_ready, ctl_start, ctl_addr, ctl_rw, ctl_wdata, grant_id,
                     oh(m_ie.gid), m_ie.addr, m_ie.rw, m_ie.wd, m_ie.gid);
          end
        end
      end
      if (rsp_valid != '0) begin
        n_checks++;
        if (exp_rsp.size() == 0) begin
          n_errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b, required none", rsp_valid);
        end else begin
          m_re = exp_rsp.pop_front();
          m_ok = (rsp_valid == oh(m_re.gid)) && (rsp_rdata == m_re.rdata) &&
                 (rsp_err == m_re.err) && (ctl_addr == m_re.addr);
`ifdef I2C_ARB_TIMEOUT_EN
          m_ok = m_ok && (ctl_abort == m_re.tmo);
`endif
          if (!m_ok) begin
            n_errors++;
            $display("FAIL rsp: got valid=%b rdata=%h err=%b addr=%h, required valid=%b rdata=%h err=%b addr=%h tmo=%b",
                     rsp_valid, rsp_rdata, rsp_err, ctl_addr, oh(m_re.gid), m_re.rdata, m_re.err, m_re.addr, m_re.tmo);
          end
        end
      end
    end
  end

  // Behavioural controller: busy one cycle after start, done three cycles later, or hang.
  ctl_t cm;
  initial begin
    ctl_busy   = 1'b0;
    model_done = 1'b0;
    ctl_rdata  = 8'h00;
    ctl_nack   = 1'b0;
    forever begin
      @(negedge clk);
      if (ctl_start && !rst) begin
        if (exp_ctl.size() == 0) begin
          cm = '{rdata: 8'h00, nack: 1'b0, hang: 1'b0};
        end else begin
          cm = exp_ctl.pop_front();
        end
        @(posedge clk);
        #1 ctl_busy = 1'b1;
        if (cm.hang) begin
          for (int k = 0; k < 300 && !rst && !w_abort; k++) @(negedge clk);
          ctl_busy = 1'b0;
        end else begin
          repeat (3) @(posedge clk);
          #1;
          ctl_busy   = 1'b0;
          model_done = 1'b1;
          ctl_rdata  = cm.rdata;
          ctl_nack   = cm.nack;
          @(posedge clk);
          #1;
          model_done = 1'b0;
          ctl_nack   = 1'b0;
        end
      end
    end
  end

  task automatic push_txn(input int g, input logic [DW-1:0] rd, input logic nk,
                          input logic hang, input logic tmo);
    iss_t ie;
    rsp_t re;
    ctl_t ce;
    ie = '{gid: g, addr: t_addr[g], rw: t_rw[g], wd: t_wd[g]};
    exp_iss.push_back(ie);
    ce = '{rdata: rd, nack: nk, hang: hang};
    exp_ctl.push_back(ce);
    if (tmo) begin
      re = '{gid: g, rdata: 8'h00, err: 1'b1, addr: t_addr[g], tmo: 1'b1};
      exp_rsp.push_back(re);
    end else if (!hang) begin
      re = '{gid: g, rdata: rd, err: nk, addr: t_addr[g], tmo: 1'b0};
      exp_rsp.push_back(re);
    end
  endtask

  task automatic go(input logic [N-1:0] mask, input bit hold, input int n);
    int got;
    got = 0;
    req_valid = mask;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got++;
        if (!hold) req_valid = req_valid & ~req_ready;
      end
    end
    req_valid = '0;
    n_checks++;
    if (got != n) begin
      n_errors++;
      $display("FAIL accept_count: got %0d accepts, required %0d", got, n);
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0 || ctl_busy) && c < 400) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= 400) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d issues and %0d responses outstanding, required 0", exp_iss.size(), exp_rsp.size());
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string nm);
    n_checks++;
    if (req_ready != '0 || rsp_valid != '0 || rsp_rdata != 8'h00 || rsp_err || ctl_start ||
        ctl_addr != 7'h00 || ctl_rw || ctl_wdata != 8'h00 || grant_id != 2'd0) begin
      n_errors++;
      $display("FAIL %s: got ready=%b rsp=%b rdata=%h err=%b start=%b addr=%h rw=%b wdata=%h gid=%0d, required all zero",
               nm, req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_start, ctl_addr, ctl_rw, ctl_wdata, grant_id);
    end
  endtask

  int   k;
  logic quiet_bad;
  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    stray_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      t_addr[i] = 7'h10 + 7'(i);
      t_rw[i]   = (i % 2 == 1);
      t_wd[i]   = 8'hA0 + 8'(i);
    end
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    // Round-robin with all four requesters held high for eight transactions.
    for (int j = 0; j < 8; j++) push_txn(j % 4, 8'hC0 + 8'(j), 1'b0, 1'b0, 1'b0);
    go(4'b1111, 1'b1, 8);
    drain();

    // Single write from requester 2 with exact one-cycle accept latency.
    t_addr[2] = 7'h50; t_rw[2] = 1'b0; t_wd[2] = 8'hA5;
    push_txn(2, 8'h11, 1'b0, 1'b0, 1'b0);
    req_valid = 4'b0100;
    @(posedge clk);
    #1;
    n_checks++;
    if (!(req_ready == 4'b0100 && ctl_start && ctl_addr == 7'h50 && ctl_wdata == 8'hA5 && !ctl_rw)) begin
      n_errors++;
      $display("FAIL issue_latency: got ready=%b start=%b addr=%h wdata=%h, required ready=0100 start=1 addr=50 wdata=a5",
               req_ready, ctl_start, ctl_addr, ctl_wdata);
    end
    @(negedge clk);
    req_valid = '0;
    drain();

    // Single read from requester 0.
    t_addr[0] = 7'h1D; t_rw[0] = 1'b1; t_wd[0] = 8'h00;
    push_txn(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    go(4'b0001, 1'b0, 1);
    drain();

    // NACK on requester 3, then a clean transaction on requester 1.
    t_addr[3] = 7'h68; t_rw[3] = 1'b0; t_wd[3] = 8'h5A;
    push_txn(3, 8'hEE, 1'b1, 1'b0, 1'b0);
    go(4'b1000, 1'b0, 1);
    drain();
    t_addr[1] = 7'h22; t_rw[1] = 1'b1; t_wd[1] = 8'h00;
    push_txn(1, 8'h77, 1'b0, 1'b0, 1'b0);
    go(4'b0010, 1'b0, 1);
    drain();

    // A done pulse while idle must produce nothing.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    quiet_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      quiet_bad = quiet_bad | (rsp_valid != '0) | (req_ready != '0);
    end
    n_checks++;
    if (quiet_bad) begin
      n_errors++;
      $display("FAIL stray_done: got activity after idle done, required none");
    end

    // Reset while the controller hangs in WAIT_DONE; pointer must restart at 0.
    t_addr[2] = 7'h2A; t_rw[2] = 1'b1; t_wd[2] = 8'h33;
    push_txn(2, 8'h00, 1'b0, 1'b1, 1'b0);
    n_hang++;
    go(4'b0100, 1'b0, 1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_txn(1, 8'h91, 1'b0, 1'b0, 1'b0);
    push_txn(3, 8'h93, 1'b0, 1'b0, 1'b0);
    go(4'b1010, 1'b0, 2);
    drain();

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog abort: controller never finishes.
    push_txn(3, 8'h00, 1'b0, 1'b1, 1'b1);
    n_hang++;
    go(4'b1000, 1'b0, 1);
    k = 0;
    while (rsp_valid == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k != 17) begin
      n_errors++;
      $display("FAIL timeout_latency: got rsp %0d cycles after issue, required 17", k);
    end
    drain();
`endif

    n_checks++;
    if (n_start != n_done + n_hang) begin
      n_errors++;
      $display("FAIL start_done_balance: got %0d starts for %0d dones + %0d hangs", n_start, n_done, n_hang);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares one I2C controller (the FSM with states IDLE..HIGH_STOP) between NUM_REQ independent requesters.
- Round-robin arbitration per single-byte transaction. Grant is held for the whole transaction.
- Sequences the controller via a start/busy/done handshake and routes the result back to the winning requester.
- Sits between the bus masters (config/sensor engines) and the I2C controller.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, I2C target address width
DATA_W, 8, data byte width
TIMEOUT_CYCLES, 4096, watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester transaction request, held until req_ready
req_ready  out  NUM_REQ  one-hot, 1-cycle accept pulse
req_addr  in  NUM_REQ*ADDR_W  packed target addresses, requester i at [i*ADDR_W +: ADDR_W]
req_rw  in  NUM_REQ  1=read, 0=write
req_wdata  in  NUM_REQ*DATA_W  packed write bytes
rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion pulse
rsp_rdata  out  DATA_W  read byte, valid with rsp_valid
rsp_err  out  1  NACK/timeout flag, valid with rsp_valid
ctl_start  out  1  1-cycle start pulse to controller
ctl_addr  out  ADDR_W  latched address
ctl_rw  out  1  latched direction
ctl_wdata  out  DATA_W  latched write byte
ctl_busy  in  1  controller not in IDLE
ctl_done  in  1  1-cycle pulse on transaction end (after HIGH_STOP)
ctl_rdata  in  DATA_W  controller read byte, valid with ctl_done
ctl_nack  in  1  address/data NACK seen, valid with ctl_done
grant_id  out  $clog2(NUM_REQ)  index of current owner (debug)

Behaviour:
- Reset (async, any state): FSM ARB_IDLE; rr_ptr=0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_start, ctl_addr, ctl_rw, ctl_wdata, grant_id.
- FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE, ARB_RESP.
- ARB_IDLE:
  - If any req_valid, pick the first asserted index searching from rr_ptr upward with wrap.
  - Latch addr/rw/wdata into ctl_* and the index into grant_id; go to ARB_ISSUE.
  - If the controller is still busy (ctl_busy=1), stay in IDLE and do not grant.
- ARB_ISSUE (1 cycle):
  - ctl_start=1 and req_ready[grant_id]=1.
  - Go to ARB_WAIT_BUSY.
  - Latency: req_valid sampled high -> req_ready/ctl_start exactly 1 cycle later.
- ARB_WAIT_BUSY:
  - On ctl_busy=1, go to ARB_WAIT_DONE.
  - If ctl_done arrives in the same cycle (degenerate controller), go straight to ARB_RESP.
- ARB_WAIT_DONE: on ctl_done, capture ctl_rdata into rsp_rdata and ctl_nack into rsp_err; go to ARB_RESP.
- ARB_RESP (1 cycle):
  - rsp_valid[grant_id]=1.
  - rr_ptr = grant_id+1, wrapping to 0 at NUM_REQ.
  - Return to ARB_IDLE.
- Throughput: at most one transaction in flight. Minimum 2 idle-side cycles (RESP->IDLE->ISSUE) between controller starts.
- ctl_addr/ctl_rw/ctl_wdata are stable from ISSUE through RESP. They are changed only in IDLE on a grant.
- rsp_rdata/rsp_err hold their values until the next capture.
- Requester dropping req_valid before req_ready: allowed only in ARB_IDLE; after latch the transaction completes regardless.
- Simultaneous requests: round-robin only. A requester re-asserting immediately waits behind all other pending requesters.
- ctl_done outside the WAIT states is ignored.
- Write transactions: rsp_rdata is captured as ctl_rdata (don't-care to requester).

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit watchdog counter, cleared on entry to ARB_WAIT_BUSY, increments in ARB_WAIT_BUSY and ARB_WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1, go to ARB_RESP with rsp_err=1 and rsp_rdata=0.
  - Extra output port ctl_abort (1 bit) pulses 1 cycle in the same cycle; controller returns to IDLE.
  - A ctl_done in the same cycle as expiry wins (normal completion, no abort).
- Not defined: no counter, no ctl_abort port; the arbiter waits indefinitely for ctl_done.

Test Plan:
- Reset mid-transaction: assert rst while in ARB_WAIT_DONE -> all outputs 0 immediately (async), FSM in IDLE, next request granted to the lowest valid index from 0.
- Single write: req_valid[2]=1, addr=7'h50, rw=0, wdata=8'hA5 -> next cycle req_ready=4'b0100, ctl_start=1, ctl_addr=7'h50, ctl_wdata=8'hA5. After ctl_done with nack=0 -> rsp_valid=4'b0100, rsp_err=0.
- Single read: req_valid[0], rw=1; controller returns ctl_rdata=8'h3C -> rsp_valid[0] 1 cycle after ctl_done, rsp_rdata=8'h3C.
- Round-robin fairness: all 4 req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3, and exactly one ctl_start per ctl_done.
- NACK: ctl_nack=1 with ctl_done -> rsp_err=1 to the owner; next grant is unaffected.
- Timeout (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): controller never pulses done -> ctl_abort and rsp_valid at cycle 16 after entering WAIT_BUSY, rsp_err=1, rsp_rdata=0.
